// File: rtl/sat_pkg.sv
// Shared types for the clause evaluation pipeline: per-clause status encoding
// and the batch summary FSM state.
package sat_pkg;

    typedef enum logic [1:0] {
        SAT        = 2'd0,
        UNRESOLVED = 2'd1,
        UNIT       = 2'd2,
        CONFLICT   = 2'd3
    } clause_status_t;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } sum_state_t;

endpackage

// File: rtl/clause_status_eval.sv
// Combinational classification of one clause from its per-literal assignment
// state into SAT / CONFLICT / UNIT / UNRESOLVED, plus the unit literal.
module clause_status_eval
    import sat_pkg::*;
#(
    parameter int NUM_LITS = 5,
    localparam int IDX_W = $clog2(NUM_LITS)
) (
    input  logic [NUM_LITS-1:0] mask_i,
    input  logic [NUM_LITS-1:0] unassign_i,
    input  logic [NUM_LITS-1:0] assign_i,
    input  logic [NUM_LITS-1:0] pole_i,
    output clause_status_t      status_o,
    output logic [IDX_W-1:0]    unit_idx_o,
    output logic                unit_val_o
);

    logic [NUM_LITS-1:0] lit_true;
    logic [NUM_LITS-1:0] lit_open;
    logic                one_open;
    logic [IDX_W-1:0]    open_idx;
    logic                open_pole;

    assign lit_true = mask_i & ~unassign_i & ~(assign_i ^ pole_i);
    assign lit_open = mask_i & unassign_i;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign one_open = (lit_open != '0) && ((lit_open & (lit_open - 1'b1)) == '0);

    always_comb begin
        open_idx  = '0;
        open_pole = 1'b0;
        for (int i = 0; i < NUM_LITS; i++) begin
            if (lit_open[i]) begin
                open_idx  = IDX_W'(i);
                open_pole = pole_i[i];
            end
        end
    end

    always_comb begin
        status_o   = UNRESOLVED;
        unit_idx_o = '0;
        unit_val_o = 1'b0;
        if (lit_true != '0) begin
            status_o = SAT;
        end else if (lit_open == '0) begin
            status_o = CONFLICT;
        end else if (one_open) begin
            status_o   = UNIT;
            unit_idx_o = open_idx;
            unit_val_o = open_pole;
        end
    end

endmodule

// File: rtl/clause_eval_pipe.sv
// Two-stage clause evaluation pipeline (S1 capture, S2 result) with a batch
// summary FSM that counts conflicts/units and reports once per batch.
module clause_eval_pipe
    import sat_pkg::*;
#(
    parameter int NUM_LITS = 5,
    parameter int CID_W    = 10,
    parameter int CNT_W    = 10,
    localparam int IDX_W   = $clog2(NUM_LITS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CID_W-1:0]    in_cid,
    input  logic                in_last,
    input  logic [NUM_LITS-1:0] in_mask,
    input  logic [NUM_LITS-1:0] in_unassign,
    input  logic [NUM_LITS-1:0] in_assign,
    input  logic [NUM_LITS-1:0] in_pole,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CID_W-1:0]    out_cid,
    output logic                out_last,
    output logic [1:0]          out_status,
    output logic [IDX_W-1:0]    out_unit_idx,
    output logic                out_unit_val,
    output logic                sum_valid,
    output logic [CNT_W-1:0]    sum_conflicts,
    output logic [CNT_W-1:0]    sum_units,
    output logic [CID_W-1:0]    sum_first_unit_cid,
    output logic                sum_first_unit_found,
    output sum_state_t          dbg_sum_state
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; a stage holds its contents while its downstream is full and stalled.
    logic                s1_valid_q, s1_valid_d;
    logic [CID_W-1:0]    s1_cid_q;
    logic                s1_last_q;
    logic [NUM_LITS-1:0] s1_mask_q, s1_unassign_q, s1_assign_q, s1_pole_q;

    logic                s2_valid_q, s2_valid_d;
    logic [CID_W-1:0]    s2_cid_q;
    logic                s2_last_q;
    clause_status_t      s2_status_q;
    logic [IDX_W-1:0]    s2_unit_idx_q;
    logic                s2_unit_val_q;

    clause_status_t      eval_status;
    logic [IDX_W-1:0]    eval_unit_idx;
    logic                eval_unit_val;

    logic in_hs, s2_ready, s1_adv, out_hs;

    assign s2_ready = ~s2_valid_q | out_ready;
    assign s1_adv   = s1_valid_q & s2_ready;
    assign in_ready = ~reset & (~s1_valid_q | s1_adv);
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = s2_valid_q & out_ready;

    assign s1_valid_d = in_hs ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    assign s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;

    clause_status_eval #(.NUM_LITS(NUM_LITS)) u_eval (
        .mask_i     (s1_mask_q),
        .unassign_i (s1_unassign_q),
        .assign_i   (s1_assign_q),
        .pole_i     (s1_pole_q),
        .status_o   (eval_status),
        .unit_idx_o (eval_unit_idx),
        .unit_val_o (eval_unit_val)
    );

    // Batch summary: acc_* holds the running batch, sum_* the last completed one.
    sum_state_t       state_q, state_d;
    logic [CNT_W-1:0] acc_conf_q, acc_conf_d, acc_units_q, acc_units_d;
    logic [CID_W-1:0] acc_cid_q, acc_cid_d;
    logic             acc_found_q, acc_found_d;
    logic [CNT_W-1:0] sum_conf_q, sum_conf_d, sum_units_q, sum_units_d;
    logic [CID_W-1:0] sum_cid_q, sum_cid_d;
    logic             sum_found_q, sum_found_d;
    logic [CNT_W-1:0] conf_inc, units_inc;
    logic [CID_W-1:0] cid_inc;
    logic             found_inc;

    always_comb begin
        state_d = ACCUM;
        case (state_q)
            ACCUM:   state_d = (out_hs && s2_last_q) ? REPORT : ACCUM;
            REPORT:  state_d = (out_hs && s2_last_q) ? REPORT : ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        conf_inc  = acc_conf_q;
        units_inc = acc_units_q;
        cid_inc   = acc_cid_q;
        found_inc = acc_found_q;
        if (s2_status_q == CONFLICT && acc_conf_q != '1) begin
            conf_inc = acc_conf_q + 1'b1;
        end
        if (s2_status_q == UNIT) begin
            if (acc_units_q != '1) begin
                units_inc = acc_units_q + 1'b1;
            end
            if (!acc_found_q) begin
                found_inc = 1'b1;
                cid_inc   = s2_cid_q;
            end
        end

        acc_conf_d  = acc_conf_q;
        acc_units_d = acc_units_q;
        acc_cid_d   = acc_cid_q;
        acc_found_d = acc_found_q;
        sum_conf_d  = sum_conf_q;
        sum_units_d = sum_units_q;
        sum_cid_d   = sum_cid_q;
        sum_found_d = sum_found_q;
        if (out_hs) begin
            if (s2_last_q) begin
                // Accumulators restart at zero so a clause accepted during REPORT
                // contributes only to the new batch.
                sum_conf_d  = conf_inc;
                sum_units_d = units_inc;
                sum_cid_d   = cid_inc;
                sum_found_d = found_inc;
                acc_conf_d  = '0;
                acc_units_d = '0;
                acc_cid_d   = '0;
                acc_found_d = 1'b0;
            end else begin
                acc_conf_d  = conf_inc;
                acc_units_d = units_inc;
                acc_cid_d   = cid_inc;
                acc_found_d = found_inc;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_cid_q      <= '0;
            s1_last_q     <= 1'b0;
            s1_mask_q     <= '0;
            s1_unassign_q <= '0;
            s1_assign_q   <= '0;
            s1_pole_q     <= '0;
            s2_valid_q    <= 1'b0;
            s2_cid_q      <= '0;
            s2_last_q     <= 1'b0;
            s2_status_q   <= SAT;
            s2_unit_idx_q <= '0;
            s2_unit_val_q <= 1'b0;
            state_q       <= ACCUM;
            acc_conf_q    <= '0;
            acc_units_q   <= '0;
            acc_cid_q     <= '0;
            acc_found_q   <= 1'b0;
            sum_conf_q    <= '0;
            sum_units_q   <= '0;
            sum_cid_q     <= '0;
            sum_found_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_hs) begin
                s1_cid_q      <= in_cid;
                s1_last_q     <= in_last;
                s1_mask_q     <= in_mask;
                s1_unassign_q <= in_unassign;
                s1_assign_q   <= in_assign;
                s1_pole_q     <= in_pole;
            end
            if (s1_adv) begin
                s2_cid_q      <= s1_cid_q;
                s2_last_q     <= s1_last_q;
                s2_status_q   <= eval_status;
                s2_unit_idx_q <= eval_unit_idx;
                s2_unit_val_q <= eval_unit_val;
            end
            state_q     <= state_d;
            acc_conf_q  <= acc_conf_d;
            acc_units_q <= acc_units_d;
            acc_cid_q   <= acc_cid_d;
            acc_found_q <= acc_found_d;
            sum_conf_q  <= sum_conf_d;
            sum_units_q <= sum_units_d;
            sum_cid_q   <= sum_cid_d;
            sum_found_q <= sum_found_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_cid      = s2_valid_q ? s2_cid_q : '0;
    assign out_last     = s2_valid_q & s2_last_q;
    assign out_status   = s2_valid_q ? s2_status_q : SAT;
    assign out_unit_idx = s2_valid_q ? s2_unit_idx_q : '0;
    assign out_unit_val = s2_valid_q & s2_unit_val_q;

    assign sum_valid            = (state_q == REPORT);
    assign sum_conflicts        = sum_conf_q;
    assign sum_units            = sum_units_q;
    assign sum_first_unit_cid   = sum_cid_q;
    assign sum_first_unit_found = sum_found_q;
    assign dbg_sum_state        = state_q;

endmodule

// File: tb/tb_clause_eval_pipe.sv
// Self-checking bench for clause_eval_pipe: directed steps plus a random
// backpressure run, scored against a golden classifier and batch model.
module tb_clause_eval_pipe;
    import sat_pkg::*;

    localparam int NL = 5;
    localparam int CW = 10;
    localparam int IW = $clog2(NL);
    localparam int EW = CW + 1 + 2 + IW + 1;

    logic          clock = 1'b0;
    logic          reset, in_valid, in_last, out_ready;
    logic [CW-1:0] in_cid;
    logic [NL-1:0] in_mask, in_unassign, in_assign, in_pole;

    logic          in_ready, out_valid, out_last, out_unit_val;
    logic [CW-1:0] out_cid;
    logic [1:0]    out_status;
    logic [IW-1:0] out_unit_idx;
    logic          sum_valid, sum_first_unit_found;
    logic [9:0]    sum_conflicts, sum_units;
    logic [CW-1:0] sum_first_unit_cid;
    sum_state_t    dbg_sum_state;

    logic          d2_in_ready, d2_out_valid, d2_out_last, d2_out_unit_val;
    logic [CW-1:0] d2_out_cid;
    logic [1:0]    d2_out_status;
    logic [IW-1:0] d2_out_unit_idx;
    logic          d2_sum_valid, d2_sum_found;
    logic [1:0]    d2_sum_conflicts, d2_sum_units;
    logic [CW-1:0] d2_sum_cid;
    sum_state_t    d2_dbg_sum_state;

    clause_eval_pipe #(.NUM_LITS(NL), .CID_W(CW), .CNT_W(10)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_cid(in_cid), .in_last(in_last), .in_mask(in_mask), .in_unassign(in_unassign),
        .in_assign(in_assign), .in_pole(in_pole), .out_valid(out_valid), .out_ready(out_ready),
        .out_cid(out_cid), .out_last(out_last), .out_status(out_status),
        .out_unit_idx(out_unit_idx), .out_unit_val(out_unit_val), .sum_valid(sum_valid),
        .sum_conflicts(sum_conflicts), .sum_units(sum_units),
        .sum_first_unit_cid(sum_first_unit_cid), .sum_first_unit_found(sum_first_unit_found),
        .dbg_sum_state(dbg_sum_state)
    );

    // Narrow-counter instance sharing all stimulus, used for saturation.
    clause_eval_pipe #(.NUM_LITS(NL), .CID_W(CW), .CNT_W(2)) dut_c2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_cid(in_cid), .in_last(in_last), .in_mask(in_mask), .in_unassign(in_unassign),
        .in_assign(in_assign), .in_pole(in_pole), .out_valid(d2_out_valid), .out_ready(out_ready),
        .out_cid(d2_out_cid), .out_last(d2_out_last), .out_status(d2_out_status),
        .out_unit_idx(d2_out_unit_idx), .out_unit_val(d2_out_unit_val), .sum_valid(d2_sum_valid),
        .sum_conflicts(d2_sum_conflicts), .sum_units(d2_sum_units),
        .sum_first_unit_cid(d2_sum_cid), .sum_first_unit_found(d2_sum_found),
        .dbg_sum_state(d2_dbg_sum_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic          rand_ready = 1'b0;
    int            n_last_sent = 0;
    int            sum_pulses = 0;
    logic          prev_sv = 1'b0;
    logic          consec_seen = 1'b0;

    int            m_conf, m_units, e_conf, e_units;
    logic          m_found, e_found, sum_pend;
    logic [CW-1:0] m_fcid, e_fcid;
    logic [EW-1:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_cnt(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [EW-1:0] golden(input logic [CW-1:0] cid, input logic last,
                                              input logic [NL-1:0] m, input logic [NL-1:0] u,
                                              input logic [NL-1:0] a, input logic [NL-1:0] p);
        int            n_true;
        int            n_open;
        int            oi;
        logic [1:0]    st;
        logic [IW-1:0] idx;
        logic          val;
        n_true = 0; n_open = 0; oi = 0; idx = '0; val = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (m[i]) begin
                if (u[i]) begin
                    n_open++;
                    oi = i;
                end else if (a[i] == p[i]) begin
                    n_true++;
                end
            end
        end
        if (n_true > 0)       st = 2'd0;
        else if (n_open == 0) st = 2'd3;
        else if (n_open == 1) begin
            st  = 2'd2;
            idx = IW'(oi);
            val = p[oi];
        end else              st = 2'd1;
        return {cid, last, st, idx, val};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [CW-1:0] cid, input logic last, input logic [NL-1:0] m,
                        input logic [NL-1:0] u, input logic [NL-1:0] a, input logic [NL-1:0] p);
        bit done;
        int waited;
        done = 0; waited = 0;
        in_valid = 1'b1; in_cid = cid; in_last = last;
        in_mask = m; in_unassign = u; in_assign = a; in_pole = p;
        while (!done) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back(golden(cid, last, m, u, a, p));
                if (last) n_last_sent++;
                done = 1;
            end else if (++waited > 200) begin
                chk("in_ready_timeout", 32'(in_ready), 32'd1);
                done = 1;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (cycles) begin
            @(posedge clock);
            #1;
        end
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum_valid", 32'(sum_valid), 32'd0);
        chk("rst_sum_conf", 32'(sum_conflicts), 32'd0);
        chk("rst_sum_units", 32'(sum_units), 32'd0);
        chk("rst_sum_found", 32'(sum_first_unit_found), 32'd0);
        chk("rst_sum_cid", 32'(sum_first_unit_cid), 32'd0);
        chk("rst_in_ready_hold", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    endtask

    // Scoreboard: sample at the falling edge, score summary first, then outputs.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            m_conf = 0; m_units = 0; m_found = 1'b0; m_fcid = '0;
            e_conf = 0; e_units = 0; e_found = 1'b0; e_fcid = '0;
            sum_pend = 1'b0;
            prev_sv = 1'b0;
        end else begin
            chk("sum_valid", 32'(sum_valid), 32'(sum_pend));
            if (sum_valid) begin
                sum_pulses++;
                if (prev_sv) consec_seen = 1'b1;
            end
            chk("sum_conflicts", 32'(sum_conflicts), 32'(sat_cnt(e_conf, 10)));
            chk("sum_units", 32'(sum_units), 32'(sat_cnt(e_units, 10)));
            chk("sum_first_cid", 32'(sum_first_unit_cid), 32'(e_fcid));
            chk("sum_found", 32'(sum_first_unit_found), 32'(e_found));
            chk("c2_sum_conflicts", 32'(d2_sum_conflicts), 32'(sat_cnt(e_conf, 2)));
            chk("c2_sum_units", 32'(d2_sum_units), 32'(sat_cnt(e_units, 2)));
            prev_sv = sum_valid;
            sum_pend = 1'b0;
            if (!out_valid) begin
                chk("idle_zero", 32'({out_cid, out_last, out_status, out_unit_idx, out_unit_val}), 32'd0);
            end else if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_result", 32'({out_cid, out_last, out_status, out_unit_idx, out_unit_val}), 32'(mon_e));
                    if (mon_e[IW+2:IW+1] == 2'd3) m_conf++;
                    if (mon_e[IW+2:IW+1] == 2'd2) begin
                        m_units++;
                        if (!m_found) begin
                            m_found = 1'b1;
                            m_fcid = mon_e[EW-1:IW+4];
                        end
                    end
                    if (mon_e[IW+3]) begin
                        e_conf = m_conf; e_units = m_units; e_found = m_found; e_fcid = m_fcid;
                        sum_pend = 1'b1;
                        m_conf = 0; m_units = 0; m_found = 1'b0; m_fcid = '0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_cid = '0; in_mask = '0; in_unassign = '0; in_assign = '0; in_pole = '0;
        do_reset(2);

        // SAT clause and two-cycle latency
        out_ready = 1'b1;
        send(10'd1, 1'b1, 5'b11111, 5'b00000, 5'b00001, 5'b00001);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_sat", 32'(out_status), 32'd0);
        drain();

        // UNIT with index/value, then empty mask as CONFLICT
        send(10'd2, 1'b0, 5'b00111, 5'b00100, 5'b00000, 5'b00011);
        tick();
        chk("unit_status", 32'(out_status), 32'd2);
        chk("unit_idx", 32'(out_unit_idx), 32'd2);
        chk("unit_val", 32'(out_unit_val), 32'd0);
        send(10'd3, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        tick();
        chk("empty_conflict", 32'(out_status), 32'd3);
        chk("conflict_idx", 32'(out_unit_idx), 32'd0);
        drain();

        // Four-clause batch
        send(10'd6, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        send(10'd7, 1'b0, 5'b00111, 5'b00100, 5'b00000, 5'b00011);
        send(10'd9, 1'b0, 5'b00011, 5'b00010, 5'b00000, 5'b00011);
        send(10'd10, 1'b1, 5'b11111, 5'b00000, 5'b00001, 5'b00001);
        drain();
        chk("b4_conflicts", 32'(sum_conflicts), 32'd1);
        chk("b4_units", 32'(sum_units), 32'd2);
        chk("b4_first_cid", 32'(sum_first_unit_cid), 32'd7);
        chk("b4_found", 32'(sum_first_unit_found), 32'd1);

        // Stall: outputs hold and input stops accepting when both stages are full
        out_ready = 1'b0;
        send(10'd30, 1'b0, 5'b11111, 5'b00011, 5'b00000, 5'b11100);
        send(10'd31, 1'b1, 5'b00011, 5'b00000, 5'b00011, 5'b00000);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'({out_cid, out_last, out_status, out_unit_idx, out_unit_val}), 32'(exp_q[0]));
            tick();
        end
        out_ready = 1'b1;
        drain();

        // Five conflicts: wide counter shows 5, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            send(10'(40 + i), 1'(i == 4), 5'b00011, 5'b00000, 5'b00011, 5'b00000);
        end
        drain();
        chk("sat_wide", 32'(sum_conflicts), 32'd5);
        chk("sat_narrow", 32'(d2_sum_conflicts), 32'd3);

        // Back-to-back last clauses give two consecutive reports
        p0 = sum_pulses;
        consec_seen = 1'b0;
        send(10'd20, 1'b1, 5'b00111, 5'b00100, 5'b00000, 5'b00011);
        send(10'd21, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        drain();
        chk("b2b_pulses", 32'(sum_pulses - p0), 32'd2);
        chk("b2b_consecutive", 32'(consec_seen), 32'd1);
        chk("b2b_conf", 32'(sum_conflicts), 32'd1);
        chk("b2b_units", 32'(sum_units), 32'd0);
        chk("b2b_found", 32'(sum_first_unit_found), 32'd0);

        // Reset with a partial batch counted and two clauses in flight
        send(10'd50, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        drain();
        out_ready = 1'b0;
        send(10'd51, 1'b0, 5'b00111, 5'b00100, 5'b00000, 5'b00011);
        send(10'd52, 1'b0, 5'b00011, 5'b00010, 5'b00000, 5'b00011);
        do_reset(1);
        out_ready = 1'b1;
        p0 = sum_pulses;
        send(10'd53, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        drain();
        chk("postrst_pulses", 32'(sum_pulses - p0), 32'd1);
        chk("postrst_conf", 32'(sum_conflicts), 32'd1);
        chk("postrst_units", 32'(sum_units), 32'd0);

        // Random clauses under 50% output backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send(10'($urandom_range(0, 1023)), 1'((i == 999) || ($urandom_range(0, 5) == 0)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        chk("total_pulses", 32'(sum_pulses), 32'(n_last_sent));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
